scanchain_host: RTL and testbench
=================================

# scanchain_host

Host-side master for the 96-bit local scan chain that wraps the SERV core. It sits on the FPGA or test-harness side of the chip pins. Each frame it:
- captures the chip's bus/register-file outputs,
- shifts the next input word in while shifting the captured word out,
- pulses the latch.

A system-side harness uses it to serve memory and register-file responses to the CPU one frame at a time, with a valid/ready handshake on both the request and the response side.

## Interface

Parameters:
- SCAN_LENGTH, default 96: number of chain bits per frame.
- CLK_DIV, default 2: system cycles per scan-clock phase (low or high); legal range is 1 and up.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request frame available.
- o_req_ready  out  1  block idle and able to accept a frame.
- i_req_data  in  SCAN_LENGTH  word to shift into the chain; bit SCAN_LENGTH-1 is shifted first.
- o_rsp_valid  out  1  captured word available.
- i_rsp_ready  in  1  consumer accepts the captured word.
- o_rsp_data  out  SCAN_LENGTH  captured word; bit SCAN_LENGTH-1 is the first bit sampled.
- o_scan_clk  out  1  chain clock; the chain shifts on its rising edge.
- o_scan_data  out  1  serial data into the chain.
- o_scan_select  out  1  high means capture module outputs on the next rising edge.
- o_latch_en  out  1  high transfers shifted data to module inputs.
- i_scan_data  in  1  serial data returned from the chain.

## Operation

- States and transitions: IDLE → CAPTURE → SHIFT → LATCH → DONE → IDLE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid&&o_req_ready, register i_req_data into the shift register and go to CAPTURE.
- CAPTURE:
  - o_scan_select=1 and o_scan_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Go to SHIFT.
- SHIFT:
  - SCAN_LENGTH periods, each low for CLK_DIV cycles then high for CLK_DIV cycles; o_scan_select=0.
  - o_scan_data presents the shift register MSB during the whole period.
  - i_scan_data is sampled on the last system cycle of each low phase and shifted into the LSB of the response register.
  - The shift register shifts left once per period.
  - The bit counter counts 0..SCAN_LENGTH-1; at terminal count plus the end of the high phase, go to LATCH.
- LATCH:
  - o_latch_en=1 for 2*CLK_DIV cycles with o_scan_clk=0.
  - Go to DONE.
- DONE:
  - o_rsp_valid=1 and o_rsp_data stable.
  - On i_rsp_ready, go to IDLE.
  - No new frame starts until the response is accepted (backpressure).
- i_req_valid outside IDLE is ignored; i_req_data is only sampled at acceptance.
- Counter widths: phase counter $clog2(CLK_DIV+1); bit counter $clog2(SCAN_LENGTH+1).

## Timing

- Reset values: o_req_ready=0 while i_rst is high, and 1 in the first cycle after release. All other outputs are 0, o_rsp_data is 0, and the state is IDLE.
- Reset mid-frame:
  - All scan outputs go low immediately (asynchronously).
  - The frame is abandoned and no response is produced.
  - The chain contents are undefined until the next full frame.
- Latency: if the request is accepted in cycle 0, o_rsp_valid rises in cycle 2*CLK_DIV*(SCAN_LENGTH+2)+1. For defaults (CLK_DIV=2, SCAN_LENGTH=96) that is cycle 393.
- Throughput: the earliest next acceptance is the cycle after o_rsp_valid&&i_rsp_ready.
  - If i_rsp_ready is already high when o_rsp_valid rises, o_req_ready is 1 in the next cycle.
- o_scan_data changes only on the cycle where o_scan_clk falls or at phase start. It is never changed in the same cycle as a rising o_scan_clk.
- o_scan_select and o_latch_en are never high in the same cycle.

## Structure

- Shared header scan_pkg.vh holds:
  - state encodings (IDLE=0, CAPTURE=1, SHIFT=2, LATCH=3, DONE=4);
  - the default SCAN_LENGTH=96.
- One sub-module, scan_clk_gen. It contains:
  - the phase counter and o_scan_clk generation;
  - pulses phase_low_end and phase_high_end;
  - an enable input, so the clock stays low when disabled.
- The FSM, shift registers and bit counter live in scanchain_host.

## Test plan

- Reset release, i_req_valid=0 → all scan outputs 0, o_req_ready=1, o_rsp_valid=0 indefinitely.
- Loopback (i_scan_data driven by a 96-flop chain model with capture value 96'hA5A5…A5) and request 96'h0123_4567_89AB_CDEF_0011_2233 → o_rsp_data=96'hA5A5…A5 at cycle 393. The model's latched inputs equal 96'h0123_4567_89AB_CDEF_0011_2233.
- CLK_DIV=1, SCAN_LENGTH=8, request 8'h81 → o_scan_data sequence 1,0,0,0,0,0,0,1 on rising edges; o_rsp_valid at cycle 21.
- Hold i_rsp_ready=0 for 50 cycles after o_rsp_valid:
  - o_rsp_data is held stable and o_req_ready=0;
  - a pulse on i_req_valid is ignored;
  - after i_rsp_ready is asserted, o_req_ready=1 in the next cycle.
- Assert i_rst during SHIFT, bit 40 → outputs are 0 in the same cycle. After release, a fresh frame completes with correct data and the full latency.
- Back-to-back frames with i_rsp_ready=1 and i_req_valid=1 held → one frame per 2*CLK_DIV*(SCAN_LENGTH+2)+2 cycles, with exactly one o_latch_en pulse per frame.

Source files
------------

// File: rtl/scanchain_host_pkg.sv
// Shared constants for the scan-chain host: FSM encodings and default chain length.
package scanchain_host_pkg;

  localparam int SCAN_LENGTH_DEF = 96;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/scanchain_host_clk_gen.sv
// Scan clock divider: CLK_DIV cycles low, then CLK_DIV cycles high, while enabled.
module scan_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scan_clk,
  output logic phase_low_end,
  output logic phase_high_end
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          high;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      high <= ~high;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign scan_clk       = en & high;
  assign phase_low_end  = en & ~high & last;
  assign phase_high_end = en &  high & last;

endmodule

// File: rtl/scanchain_host.sv
// Host-side scan chain master: capture, shift a full frame in/out, latch, then hand back the response.
module scanchain_host
  import scanchain_host_pkg::*;
#(
  parameter int SCAN_LENGTH = SCAN_LENGTH_DEF,
  parameter int CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [SCAN_LENGTH-1:0] i_req_data,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [SCAN_LENGTH-1:0] o_rsp_data,
  output logic                   o_scan_clk,
  output logic                   o_scan_data,
  output logic                   o_scan_select,
  output logic                   o_latch_en,
  input  logic                   i_scan_data
);

  localparam int BW = $clog2(SCAN_LENGTH + 1);

  logic [2:0]             state;
  logic [SCAN_LENGTH-1:0] sreg;
  logic [SCAN_LENGTH-1:0] rsp;
  logic [BW-1:0]          bit_cnt;
  logic                   gen_en;
  logic                   gen_clk;
  logic                   low_end;
  logic                   high_end;

  // The divider also times the latch window; its clock is masked there.
  assign gen_en = (state == ST_CAPTURE) || (state == ST_SHIFT) || (state == ST_LATCH);

  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk           (clk),
    .rst           (i_rst),
    .en            (gen_en),
    .scan_clk      (gen_clk),
    .phase_low_end (low_end),
    .phase_high_end(high_end)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      rsp     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_req_valid) begin
          sreg    <= i_req_data;
          bit_cnt <= '0;
          state   <= ST_CAPTURE;
        end
        ST_CAPTURE: if (high_end) state <= ST_SHIFT;
        ST_SHIFT: begin
          // Sample just before the rising edge so the chain output is settled.
          if (low_end) rsp <= {rsp[SCAN_LENGTH-2:0], i_scan_data};
          if (high_end) begin
            sreg <= sreg << 1;
            if (bit_cnt == BW'(SCAN_LENGTH - 1)) state <= ST_LATCH;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_LATCH: if (high_end) state <= ST_DONE;
        ST_DONE:  if (i_rsp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready   = (state == ST_IDLE) && !i_rst;
  assign o_rsp_valid   = (state == ST_DONE);
  assign o_rsp_data    = rsp;
  assign o_scan_clk    = gen_clk && (state != ST_LATCH);
  assign o_scan_data   = (state == ST_SHIFT) && sreg[SCAN_LENGTH-1];
  assign o_scan_select = (state == ST_CAPTURE);
  assign o_latch_en    = (state == ST_LATCH);

endmodule

// File: tb/tb_scanchain_host.sv
// Bench for scanchain_host: per-cycle frame-timing model plus a behavioural scan chain as the far end.
module tb_scanchain_host;

  localparam int N   = 96;
  localparam int D   = 2;
  localparam int LAT = 2 * D * (N + 2) + 1;
  localparam int SN  = 8;
  localparam int SD  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // default-size instance
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic [N-1:0] req_data = '0, rsp_data;
  logic         sclk, sdo, ssel, slat, sdi;

  scanchain_host #(.SCAN_LENGTH(N), .CLK_DIV(D)) dut (
    .clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_data(req_data), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_scan_clk(sclk), .o_scan_data(sdo),
    .o_scan_select(ssel), .o_latch_en(slat), .i_scan_data(sdi)
  );

  // small instance
  logic          s_rst = 1'b1;
  logic          s_valid = 1'b0, s_ready, s_rvalid, s_rready = 1'b0;
  logic [SN-1:0] s_data = '0, s_rdata;
  logic          s_sclk, s_sdo, s_sel, s_lat, s_sdi;

  scanchain_host #(.SCAN_LENGTH(SN), .CLK_DIV(SD)) dut_s (
    .clk(clk), .i_rst(s_rst), .i_req_valid(s_valid), .o_req_ready(s_ready),
    .i_req_data(s_data), .o_rsp_valid(s_rvalid), .i_rsp_ready(s_rready),
    .o_rsp_data(s_rdata), .o_scan_clk(s_sclk), .o_scan_data(s_sdo),
    .o_scan_select(s_sel), .o_latch_en(s_lat), .i_scan_data(s_sdi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // far-end chain for the default instance
  logic [N-1:0] chain = '0, latched = '0, cap = '0;
  logic         prev_sclk = 1'b0;
  assign sdi = chain[N-1];

  // frame model: expected outputs follow from cycles elapsed since acceptance
  bit           m_busy = 1'b0;
  int           t0 = 0;
  logic [N-1:0] m_req = '0, m_cap = '0;

  initial forever begin
    int k, j;
    logic e_rdy, e_vld, e_clk, e_dat, e_sel, e_lat;
    @(negedge clk);
    k = cyc - t0;
    {e_rdy, e_vld, e_clk, e_dat, e_sel, e_lat} = '0;
    if (rst) begin
      m_busy = 1'b0;
      check("reset rsp_data", rsp_data, '0);
    end else if (!m_busy) begin
      e_rdy = 1'b1;
    end else if (k <= 2 * D) begin
      e_sel = 1'b1;
      e_clk = (k - 1) >= D;
    end else if (k <= 2 * D + 2 * D * N) begin
      j     = k - 1 - 2 * D;
      e_clk = (j % (2 * D)) >= D;
      e_dat = m_req[N - 1 - j / (2 * D)];
    end else if (k < LAT) begin
      e_lat = 1'b1;
    end else begin
      e_vld = 1'b1;
      check("rsp_data", rsp_data, m_cap);
      if (k == LAT) check("latched inputs", latched, m_req);
    end
    check("outputs {rdy,vld,clk,dat,sel,lat}",
          N'({req_ready, rsp_valid, sclk, sdo, ssel, slat}),
          N'({e_rdy, e_vld, e_clk, e_dat, e_sel, e_lat}));
    if (!rst) begin
      if (!m_busy && req_valid) begin
        m_busy = 1'b1;
        t0     = cyc;
        m_req  = req_data;
        m_cap  = cap;
      end else if (m_busy && k >= LAT && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
    if (sclk && !prev_sclk) begin
      if (ssel) chain = cap;
      else      chain = {chain[N-2:0], sdo};
    end
    prev_sclk = sclk;
    if (slat) latched = chain;
  end

  // far-end chain for the small instance
  logic [SN-1:0] s_chain = '0, s_latched = '0, s_seq = '0;
  logic          s_prev = 1'b0;
  int            s_rises = 0;
  bit            s_done = 1'b0;
  assign s_sdi = s_chain[SN-1];

  initial forever begin
    @(negedge clk);
    if (s_sclk && !s_prev) begin
      s_rises++;
      if (s_sel) s_chain = 8'h3C;
      else begin
        s_seq   = {s_seq[SN-2:0], s_sdo};
        s_chain = {s_chain[SN-2:0], s_sdo};
      end
    end
    s_prev = s_sclk;
    if (s_lat) s_latched = s_chain;
  end

  initial begin
    int ta, tr;
    tick(2);
    s_rst = 1'b0;
    tick(2);
    s_data  = 8'h81;
    s_valid = 1'b1;
    ta = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin ta = cyc; break; end
    end
    tick(1);
    s_valid = 1'b0;
    tr = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_rvalid) begin tr = cyc; break; end
    end
    check("small accept/rsp seen", N'((ta >= 0) && (tr >= 0)), N'(1));
    check("small latency", N'(tr - ta), N'(21));
    check("small scan_data sequence", N'(s_seq), N'(8'h81));
    check("small rising edges", N'(s_rises), N'(9));
    check("small rsp_data", N'(s_rdata), N'(8'h3C));
    check("small latched", N'(s_latched), N'(8'h81));
    s_rready = 1'b1;
    tick(1);
    check("small req_ready after accept", N'(s_ready), N'(1));
    s_rready = 1'b0;
    s_done = 1'b1;
  end

  task automatic send(input logic [N-1:0] d, output int ta);
    req_data  = d;
    req_valid = 1'b1;
    ta = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_ready) begin ta = cyc; break; end
    end
    tick(1);
    req_valid = 1'b0;
    if (ta < 0) check("accept timeout", N'(0), N'(1));
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin t = cyc; break; end
    end
    if (t < 0) check("response timeout", N'(0), N'(1));
  endtask

  localparam logic [N-1:0] REQ1 = 96'h0123_4567_89AB_CDEF_0011_2233;

  initial begin
    int ta, tr, lc, d;
    int rises[$];
    int lrises[$];
    logic pv, pl;
    tick(3);
    check("in reset outputs", N'({req_ready, rsp_valid, sclk, sdo, ssel, slat}), N'(0));
    rst = 1'b0;
    tick(20);
    check("idle after reset", N'({req_ready, rsp_valid, sclk, sdo, ssel, slat}), N'(6'b100000));

    // loopback frame with backpressure
    cap = {12{8'hA5}};
    send(REQ1, ta);
    wait_rsp(tr);
    check("frame1 latency", N'(tr - ta), N'(393));
    check("frame1 rsp_data", rsp_data, {12{8'hA5}});
    check("frame1 latched", latched, REQ1);
    tick(20);
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(28);
    check("held rsp_valid", N'({rsp_valid, req_ready}), N'(2'b10));
    rsp_ready = 1'b1;
    tick(1);
    check("req_ready after rsp accept", N'(req_ready), N'(1));
    rsp_ready = 1'b0;

    // reset during shift, bit 40 high phase
    cap = {$urandom, $urandom, $urandom};
    send({$urandom, $urandom, $urandom}, ta);
    tick(166);
    check("pre-reset scan_clk high", N'(sclk), N'(1));
    rst = 1'b1;
    #1;
    check("async reset outputs", N'({req_ready, rsp_valid, sclk, sdo, ssel, slat}), N'(0));
    check("async reset rsp_data", rsp_data, '0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // random frames
    for (int f = 0; f < 4; f++) begin
      cap = {$urandom, $urandom, $urandom};
      send({$urandom, $urandom, $urandom}, ta);
      wait_rsp(tr);
      check("random frame latency", N'(tr - ta), N'(LAT));
      d = $urandom_range(1, 5);
      tick(d);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
    end

    // back-to-back streaming
    cap       = {$urandom, $urandom, $urandom};
    req_data  = {$urandom, $urandom, $urandom};
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    pv = 1'b0;
    pl = 1'b0;
    for (int i = 0; i < 3 * (LAT + 1) + 20; i++) begin
      @(negedge clk);
      if (rsp_valid && !pv) rises.push_back(cyc);
      if (slat && !pl) lrises.push_back(cyc);
      pv = rsp_valid;
      pl = slat;
    end
    req_valid = 1'b0;
    check("b2b frames seen", N'(rises.size() >= 3), N'(1));
    if (rises.size() >= 3) begin
      check("b2b period 1", N'(rises[1] - rises[0]), N'(LAT + 1));
      check("b2b period 2", N'(rises[2] - rises[1]), N'(LAT + 1));
      lc = 0;
      foreach (lrises[i]) if (lrises[i] > rises[0] && lrises[i] <= rises[2]) lc++;
      check("latch pulses per frame", N'(lc), N'(2));
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    rsp_ready = 1'b0;
    tick(2);

    for (int i = 0; i < 1000 && !s_done; i++) @(negedge clk);
    check("small test finished", N'(s_done), N'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
